// File: rtl/axi4lite_req_sequencer_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite request sequencer.
package axi4lite_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ0  = 1'b0;
  localparam logic REQ1  = 1'b1;
  localparam int   CNT_W = 8;

endpackage

// File: rtl/axi4lite_req_sequencer_if.sv
// Bundle of requester-side and master-side signals around the sequencer.
interface axi4lite_req_sequencer_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic                  r0_req;
  logic                  r0_we;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_ack;
  logic                  r0_err;
  logic [DATA_WIDTH-1:0] r0_rdata;

  logic                  r1_req;
  logic                  r1_we;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_ack;
  logic                  r1_err;
  logic [DATA_WIDTH-1:0] r1_rdata;

  logic                  start_write;
  logic                  start_read;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  done;
  logic                  busy;
  logic                  grant_id;

  // The sequencer itself
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  read_data, done,
    output r0_ack, r0_err, r0_rdata,
    output r1_ack, r1_err, r1_rdata,
    output start_write, start_read, write_addr, read_addr, write_data,
    output busy, grant_id
  );

  // Requesters plus the downstream master, seen from outside
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output read_data, done,
    input  r0_ack, r0_err, r0_rdata,
    input  r1_ack, r1_err, r1_rdata,
    input  start_write, start_read, write_addr, read_addr, write_data,
    input  busy, grant_id
  );

endinterface

// File: rtl/axi4lite_req_sequencer_rr_arb2.sv
// Two-way round-robin pick: under contention the requester that did not win last time wins.
module rr_arb2
  import axi4lite_seq_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Combinational grant decision
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = REQ0;
    case (req_i)
      2'b01: begin
        grant_valid_o = 1'b1;
        grant_id_o    = REQ0;
      end
      2'b10: begin
        grant_valid_o = 1'b1;
        grant_id_o    = REQ1;
      end
      2'b11: begin
        grant_valid_o = 1'b1;
        grant_id_o    = ~last_grant_i;
      end
      default: begin
        grant_valid_o = 1'b0;
        grant_id_o    = REQ0;
      end
    endcase
  end

endmodule

// File: rtl/axi4lite_req_sequencer.sv
// Shares one AXI4-Lite master user port between two requesters, one transaction at a time,
// with a bounded wait for the master's done pulse.
module axi4lite_req_sequencer
  import axi4lite_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                     clk,
  input logic                     rst,
  axi4lite_req_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_id_q, grant_id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  start_write_q, start_write_d;
  logic                  start_read_q, start_read_d;
  logic                  r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
  logic                  r0_err_q, r0_err_d, r1_err_q, r1_err_d;
  logic [DATA_WIDTH-1:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;

  logic                  arb_valid, arb_id;
  logic                  resp_fire, resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  rr_arb2 u_arb (
    .req_i         ({bus.r1_req, bus.r0_req}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (arb_valid),
    .grant_id_o    (arb_id)
  );

  // Next-state, request latching and timeout counting
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    start_write_d = 1'b0;
    start_read_d  = 1'b0;
    resp_fire     = 1'b0;
    resp_err      = 1'b0;
    resp_data     = {DATA_WIDTH{1'b0}};
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_id_d    = arb_id;
          last_grant_d  = arb_id;
          we_d          = (arb_id == REQ1) ? bus.r1_we    : bus.r0_we;
          addr_d        = (arb_id == REQ1) ? bus.r1_addr  : bus.r0_addr;
          wdata_d       = (arb_id == REQ1) ? bus.r1_wdata : bus.r0_wdata;
          start_write_d = (arb_id == REQ1) ? bus.r1_we    : bus.r0_we;
          start_read_d  = (arb_id == REQ1) ? ~bus.r1_we   : ~bus.r0_we;
          state_d       = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        // done takes priority over a coincident timeout
        if (bus.done) begin
          resp_fire = 1'b1;
          resp_data = we_q ? {DATA_WIDTH{1'b0}} : bus.read_data;
          state_d   = RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
          state_d   = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Route the response only to the granted requester
  always_comb begin
    r0_ack_d   = 1'b0;
    r1_ack_d   = 1'b0;
    r0_err_d   = 1'b0;
    r1_err_d   = 1'b0;
    r0_rdata_d = {DATA_WIDTH{1'b0}};
    r1_rdata_d = {DATA_WIDTH{1'b0}};
    if (resp_fire) begin
      if (grant_id_q == REQ1) begin
        r1_ack_d   = 1'b1;
        r1_err_d   = resp_err;
        r1_rdata_d = resp_data;
      end else begin
        r0_ack_d   = 1'b1;
        r0_err_d   = resp_err;
        r0_rdata_d = resp_data;
      end
    end else begin
      r0_ack_d = 1'b0;
      r1_ack_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ1;
      grant_id_q    <= REQ0;
      we_q          <= 1'b0;
      addr_q        <= {ADDR_WIDTH{1'b0}};
      wdata_q       <= {DATA_WIDTH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      start_write_q <= 1'b0;
      start_read_q  <= 1'b0;
      r0_ack_q      <= 1'b0;
      r1_ack_q      <= 1'b0;
      r0_err_q      <= 1'b0;
      r1_err_q      <= 1'b0;
      r0_rdata_q    <= {DATA_WIDTH{1'b0}};
      r1_rdata_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      cnt_q         <= cnt_d;
      start_write_q <= start_write_d;
      start_read_q  <= start_read_d;
      r0_ack_q      <= r0_ack_d;
      r1_ack_q      <= r1_ack_d;
      r0_err_q      <= r0_err_d;
      r1_err_q      <= r1_err_d;
      r0_rdata_q    <= r0_rdata_d;
      r1_rdata_q    <= r1_rdata_d;
    end
  end

  assign bus.start_write = start_write_q;
  assign bus.start_read  = start_read_q;
  assign bus.write_addr  = addr_q;
  assign bus.read_addr   = addr_q;
  assign bus.write_data  = wdata_q;
  assign bus.r0_ack      = r0_ack_q;
  assign bus.r1_ack      = r1_ack_q;
  assign bus.r0_err      = r0_err_q;
  assign bus.r1_err      = r1_err_q;
  assign bus.r0_rdata    = r0_rdata_q;
  assign bus.r1_rdata    = r1_rdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_axi4lite_req_sequencer.sv
// Directed bench for axi4lite_req_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_axi4lite_req_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi4lite_req_sequencer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_if ();

  axi4lite_req_sequencer #(
    .ADDR_WIDTH     (2),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw"},    32'(bus_if.start_write), 32'd0);
    chk({tag, "_sr"},    32'(bus_if.start_read),  32'd0);
    chk({tag, "_busy"},  32'(bus_if.busy),        32'd0);
    chk({tag, "_gid"},   32'(bus_if.grant_id),    32'd0);
    chk({tag, "_ack0"},  32'(bus_if.r0_ack),      32'd0);
    chk({tag, "_ack1"},  32'(bus_if.r1_ack),      32'd0);
    chk({tag, "_err0"},  32'(bus_if.r0_err),      32'd0);
    chk({tag, "_waddr"}, 32'(bus_if.write_addr),  32'd0);
    chk({tag, "_raddr"}, 32'(bus_if.read_addr),   32'd0);
    chk({tag, "_wdata"}, 32'(bus_if.write_data),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit       exp_id;
    logic [7:0] rd;
    bus_if.r0_req = 1'b0; bus_if.r0_we = 1'b0; bus_if.r0_addr = 2'd0; bus_if.r0_wdata = 8'h00;
    bus_if.r1_req = 1'b0; bus_if.r1_we = 1'b0; bus_if.r1_addr = 2'd0; bus_if.r1_wdata = 8'h00;
    bus_if.done = 1'b0; bus_if.read_data = 8'h00;

    // Reset state
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // r0 write 0xA5 to addr 2, done three cycles after start_write
    bus_if.r0_req = 1'b1; bus_if.r0_we = 1'b1; bus_if.r0_addr = 2'd2; bus_if.r0_wdata = 8'hA5;
    tick();
    chk("w_start_write", 32'(bus_if.start_write), 32'd1);
    chk("w_start_read",  32'(bus_if.start_read),  32'd0);
    chk("w_addr",        32'(bus_if.write_addr),  32'd2);
    chk("w_data",        32'(bus_if.write_data),  32'hA5);
    chk("w_busy",        32'(bus_if.busy),        32'd1);
    tick();
    chk("w_start_pulse", 32'(bus_if.start_write), 32'd0);
    tick(); tick();
    bus_if.done = 1'b1;
    chk("w_no_early_ack", 32'(bus_if.r0_ack), 32'd0);
    tick();
    bus_if.done = 1'b0; bus_if.r0_req = 1'b0;
    chk("w_ack0",  32'(bus_if.r0_ack),     32'd1);
    chk("w_err0",  32'(bus_if.r0_err),     32'd0);
    chk("w_ack1",  32'(bus_if.r1_ack),     32'd0);
    chk("w_addr_hold", 32'(bus_if.write_addr), 32'd2);
    tick();
    chk("w_ack_pulse", 32'(bus_if.r0_ack), 32'd0);
    chk("w_idle",      32'(bus_if.busy),   32'd0);

    // r1 read from addr 1 returning 0x3C
    bus_if.r1_req = 1'b1; bus_if.r1_we = 1'b0; bus_if.r1_addr = 2'd1;
    tick();
    chk("r_start_read",  32'(bus_if.start_read),  32'd1);
    chk("r_start_write", 32'(bus_if.start_write), 32'd0);
    chk("r_addr",        32'(bus_if.read_addr),   32'd1);
    chk("r_gid_issue",   32'(bus_if.grant_id),    32'd1);
    tick();
    chk("r_gid_wait",    32'(bus_if.grant_id),    32'd1);
    bus_if.done = 1'b1; bus_if.read_data = 8'h3C;
    tick();
    bus_if.done = 1'b0; bus_if.r1_req = 1'b0;
    chk("r_ack1",  32'(bus_if.r1_ack),   32'd1);
    chk("r_rdata", 32'(bus_if.r1_rdata), 32'h3C);
    chk("r_err1",  32'(bus_if.r1_err),   32'd0);
    chk("r_ack0",  32'(bus_if.r0_ack),   32'd0);
    chk("r_gid_resp", 32'(bus_if.grant_id), 32'd1);
    tick();
    chk("r_gid_hold", 32'(bus_if.grant_id), 32'd1);

    // Fairness from reset: both requesting continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.r0_req = 1'b1; bus_if.r0_we = 1'b1; bus_if.r0_addr = 2'd0; bus_if.r0_wdata = 8'h11;
    bus_if.r1_req = 1'b1; bus_if.r1_we = 1'b0; bus_if.r1_addr = 2'd3;
    for (int t = 0; t < 4; t++) begin
      exp_id = t[0];
      rd = 8'h40 + 8'(t);
      tick();
      chk("fair_gid",  32'(bus_if.grant_id),    32'(exp_id));
      chk("fair_sw",   32'(bus_if.start_write), 32'(!exp_id));
      chk("fair_sr",   32'(bus_if.start_read),  32'(exp_id));
      chk("fair_excl", 32'(bus_if.start_write & bus_if.start_read), 32'd0);
      chk("fair_busy_issue", 32'(bus_if.busy), 32'd1);
      tick();
      chk("fair_busy_wait", 32'(bus_if.busy), 32'd1);
      bus_if.done = 1'b1; bus_if.read_data = rd;
      tick();
      bus_if.done = 1'b0;
      chk("fair_ack0",   32'(bus_if.r0_ack),   32'(!exp_id));
      chk("fair_ack1",   32'(bus_if.r1_ack),   32'(exp_id));
      chk("fair_rdata1", 32'(bus_if.r1_rdata), exp_id ? 32'(rd) : 32'd0);
      chk("fair_rdata0", 32'(bus_if.r0_rdata), 32'd0);
      tick();
      chk("fair_idle", 32'(bus_if.busy), 32'd0);
    end
    bus_if.r0_req = 1'b0; bus_if.r1_req = 1'b0;

    // Timeout: r0 read, done never arrives
    bus_if.r0_req = 1'b1; bus_if.r0_we = 1'b0; bus_if.r0_addr = 2'd3; bus_if.read_data = 8'hFF;
    tick();
    chk("to_start_read", 32'(bus_if.start_read), 32'd1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_noack", 32'(bus_if.r0_ack), 32'd0);
    end
    tick();
    bus_if.r0_req = 1'b0;
    chk("to_ack0",  32'(bus_if.r0_ack),   32'd1);
    chk("to_err0",  32'(bus_if.r0_err),   32'd1);
    chk("to_rdata", 32'(bus_if.r0_rdata), 32'd0);
    chk("to_ack1",  32'(bus_if.r1_ack),   32'd0);
    tick();
    chk("to_err_pulse", 32'(bus_if.r0_err), 32'd0);
    bus_if.r1_req = 1'b1; bus_if.r1_we = 1'b1; bus_if.r1_addr = 2'd0; bus_if.r1_wdata = 8'h5A;
    tick();
    chk("after_to_sw",    32'(bus_if.start_write), 32'd1);
    chk("after_to_wdata", 32'(bus_if.write_data),  32'h5A);
    chk("after_to_gid",   32'(bus_if.grant_id),    32'd1);
    tick();
    bus_if.done = 1'b1;
    tick();
    bus_if.done = 1'b0; bus_if.r1_req = 1'b0;
    chk("after_to_ack1", 32'(bus_if.r1_ack), 32'd1);
    chk("after_to_err1", 32'(bus_if.r1_err), 32'd0);
    tick();

    // Reset during WAIT abandons the transaction
    bus_if.r0_req = 1'b1; bus_if.r0_we = 1'b0; bus_if.r0_addr = 2'd2;
    tick();
    chk("rw_start_read", 32'(bus_if.start_read), 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rst_wait");
    rst = 1'b0; bus_if.r0_req = 1'b0; bus_if.done = 1'b1; bus_if.read_data = 8'hEE;
    tick();
    chk("rw_done_ignored_busy", 32'(bus_if.busy),   32'd0);
    chk("rw_done_ignored_ack0", 32'(bus_if.r0_ack), 32'd0);
    chk("rw_done_ignored_ack1", 32'(bus_if.r1_ack), 32'd0);
    bus_if.done = 1'b0;
    bus_if.r1_req = 1'b1; bus_if.r1_we = 1'b0; bus_if.r1_addr = 2'd1;
    tick();
    chk("rw_r1_gid",   32'(bus_if.grant_id),   32'd1);
    chk("rw_r1_sr",    32'(bus_if.start_read), 32'd1);
    chk("rw_r1_raddr", 32'(bus_if.read_addr),  32'd1);
    tick();
    bus_if.done = 1'b1; bus_if.read_data = 8'h77;
    tick();
    bus_if.done = 1'b0; bus_if.r1_req = 1'b0;
    chk("rw_r1_ack",   32'(bus_if.r1_ack),   32'd1);
    chk("rw_r1_rdata", 32'(bus_if.r1_rdata), 32'h77);
    tick();

    // done coincides with the final timeout cycle: done wins
    bus_if.r0_req = 1'b1; bus_if.r0_we = 1'b0; bus_if.r0_addr = 2'd0;
    tick();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("edge_wait_noack", 32'(bus_if.r0_ack), 32'd0);
    end
    tick();
    bus_if.done = 1'b1; bus_if.read_data = 8'h96;
    tick();
    bus_if.done = 1'b0; bus_if.r0_req = 1'b0;
    chk("edge_ack0",  32'(bus_if.r0_ack),   32'd1);
    chk("edge_err0",  32'(bus_if.r0_err),   32'd0);
    chk("edge_rdata", 32'(bus_if.r0_rdata), 32'h96);
    tick();
    chk("edge_idle", 32'(bus_if.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_req_sequencer.md
Name: axi4lite_req_sequencer

Overview:
- Shares one AXI4-Lite master user interface (start_write/start_read/addr/data/done) between two independent requesters.
- Round-robin arbitration; one transaction in flight.
- Each transaction: issue pulse, wait for master done (with timeout), return ack plus read data or error to the granted requester.
- Sits between the control logic and the axi4lite_master instance.

Parameters:
- ADDR_WIDTH, 2, register address width; matches the master's write_addr/read_addr.
- DATA_WIDTH, 8, data width of write/read data.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before aborting with an error; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- r0_req  input  1  requester 0 request; held high with stable fields until r0_ack.
- r0_we  input  1  1 = write, 0 = read.
- r0_addr  input  ADDR_WIDTH  target register address.
- r0_wdata  input  DATA_WIDTH  write data (ignored for reads).
- r0_ack  output  1  one-cycle completion pulse.
- r0_err  output  1  valid with r0_ack; 1 = timeout.
- r0_rdata  output  DATA_WIDTH  read data, valid with r0_ack.
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata  (same as r0_*, for requester 1).
- start_write  output  1  one-cycle pulse to the master.
- start_read  output  1  one-cycle pulse to the master.
- write_addr  output  ADDR_WIDTH  write address to the master.
- read_addr  output  ADDR_WIDTH  read address to the master.
- write_data  output  DATA_WIDTH  write data to the master.
- read_data  input  DATA_WIDTH  read data from the master; sampled when done = 1.
- done  input  1  master completion pulse.
- busy  output  1  1 when state != IDLE.
- grant_id  output  1  requester currently owning the master; holds its last value in IDLE.

Behaviour:
- Reset (rst = 1 at an edge):
  - state = IDLE.
  - All outputs 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - Timeout counter = 0.
  - Reset mid-transaction abandons it: no ack is issued and start_* is 0 from the next edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples r0_req/r1_req.
  - If none asserted, stay in IDLE.
  - If one asserted, grant it.
  - If both asserted, grant !last_grant.
  - On a grant: latch we/addr/wdata into write_addr/read_addr/write_data registers, set grant_id and last_grant, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - start_write = we, start_read = !we; never both.
  - Address/data registers stay stable from ISSUE through RESP.
  - Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - done = 1: capture read_data (reads) or 0 (writes) into the response data register, err = 0, go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES - 1: response data = 0, err = 1, go to RESP.
  - done on the same cycle as the timeout condition: done wins, err = 0.
- RESP (exactly 1 cycle):
  - rX_ack = 1 only for grant_id; rX_rdata and rX_err valid this cycle.
  - The non-granted requester sees ack/err/rdata = 0.
  - Counter cleared; go to IDLE.
  - Requests are not sampled in RESP. The requester must drop req at the edge after ack; a req still high in the following IDLE is treated as a new transaction.
- done outside WAIT is ignored (no state change).
- Latency:
  - req sampled in IDLE at edge k → start_* high in cycle k+1.
  - done seen at edge d → ack high in cycle d+1.
  - Minimum req-to-ack is 4 cycles.
- Fairness: with both requesters continuously requesting, grants strictly alternate.
- start_*, ack, and err are registered outputs; no combinational path from any input to any output.
- Counter width is 8 bits; it never wraps because it is cleared in RESP and at reset.

Decomposition:
- Package axi4lite_seq_pkg:
  - FSM state encoding (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3).
  - Requester ID constants REQ0 = 0, REQ1 = 1.
  - Counter width constant CNT_W = 8.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req[1:0], last_grant) → (grant_valid, grant_id).
- FSM, latches and timeout counter stay in the top.

Test Plan:
- r0 write (we = 1, addr = 2, wdata = 0xA5), master model pulses done 3 cycles after start_write → start_write a 1-cycle pulse with write_addr = 2, write_data = 0xA5; r0_ack exactly 1 cycle after done, r0_err = 0, r1_ack never asserted.
- r1 read (addr = 1), model returns read_data = 0x3C with done → start_read pulse, read_addr = 1; r1_ack with r1_rdata = 0x3C, r1_err = 0; grant_id = 1 throughout.
- r0 and r1 both requesting continuously for 4 transactions from reset → grant order 0, 1, 0, 1; start_write and start_read never high together; busy low only for the single IDLE cycle between transactions.
- Read with done never asserted, TIMEOUT_CYCLES = 15 → ack after exactly 15 WAIT cycles, err = 1, rdata = 0x00; the next request proceeds normally.
- rst = 1 during WAIT → next cycle all outputs 0 and busy = 0; a later done pulse is ignored; after rst drops, r1 (sole requester) is served normally.
- done asserted in the same cycle the timeout is reached → err = 0 and rdata = read_data.
